writeback_stage: RTL and testbench

- Result staging and writeback pipe for the dual-issue (even/odd) SPU-lite datapath.
- Sits directly upstream of the register file and drives its rt_even/rt_odd data, address and write-enable inputs.
- Execution units hand in a finished result plus the number of cycles left until retirement. The block ages each result, then presents it for register-file write exactly that many cycles later.
- It also gives combinational forwarding lookup of in-flight results to operand fetch.

---
 rtl/writeback_stage.sv | 128 ++++++++++++
 tb/tb_writeback_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Result staging and writeback pipe for the even/odd SPU-lite datapath.
// Ages each result by its retire latency, then drives the register-file write ports; also forwards in-flight results.
module writeback_stage #(
    parameter int WIDTH   = 128,
    parameter int LOGSIZE = 7,
    parameter int DEPTH   = 7,
    parameter int NQ      = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_in,
    input  logic                          even_valid_in,
    input  logic [LOGSIZE-1:0]            even_addr_in,
    input  logic [WIDTH-1:0]              even_data_in,
    input  logic [2:0]                    even_lat_in,
    input  logic                          odd_valid_in,
    input  logic [LOGSIZE-1:0]            odd_addr_in,
    input  logic [WIDTH-1:0]              odd_data_in,
    input  logic [2:0]                    odd_lat_in,
    output logic [WIDTH-1:0]              rt_even_data_out,
    output logic [LOGSIZE-1:0]            rt_even_addr_out,
    output logic                          wr_en_even_out,
    output logic [WIDTH-1:0]              rt_odd_data_out,
    output logic [LOGSIZE-1:0]            rt_odd_addr_out,
    output logic                          wr_en_odd_out,
    input  logic [NQ-1:0][LOGSIZE-1:0]    fwd_addr_in,
    output logic [NQ-1:0]                 fwd_hit_out,
    output logic [NQ-1:0][WIDTH-1:0]      fwd_data_out,
    output logic                          collision_out,
    output logic                          lat_err_out
);

    typedef struct packed {
        logic               valid;
        logic [LOGSIZE-1:0] addr;
        logic [WIDTH-1:0]   data;
    } entry_t;

    // Index 0 is the even pipe, index 1 the odd pipe.
    entry_t [1:0][DEPTH-1:0]  pos_q;
    entry_t [1:0][DEPTH-1:0]  pos_d;
    logic                     collision_q;
    logic                     lat_err_q;
    logic                     collision_set;
    logic                     lat_err_set;

    logic [1:0]               in_valid;
    logic [1:0][LOGSIZE-1:0]  in_addr;
    logic [1:0][WIDTH-1:0]    in_data;
    logic [1:0][2:0]          in_lat;

    assign in_valid = {odd_valid_in, even_valid_in};
    assign in_addr  = {odd_addr_in,  even_addr_in};
    assign in_data  = {odd_data_in,  even_data_in};
    assign in_lat   = {odd_lat_in,   even_lat_in};

    // Invalid positions are always held at all-zero, so idle outputs read 0.
    always_comb begin
        pos_d         = '0;
        collision_set = 1'b0;
        lat_err_set   = 1'b0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned k = 0; k < DEPTH - 1; k++) begin
                pos_d[p][k] = pos_q[p][k+1];
            end
            if (in_valid[p] && !flush_in) begin
                if (in_lat[p] == 3'd0 || 32'(in_lat[p]) > 32'(DEPTH)) begin
                    lat_err_set = 1'b1;
                end else begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        if (32'(in_lat[p]) == k + 1) begin
                            pos_d[p][k].valid = 1'b1;
                            pos_d[p][k].addr  = in_addr[p];
                            pos_d[p][k].data  = in_data[p];
                        end
                    end
                    // The entry about to shift into the target slot is overwritten.
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        if (32'(in_lat[p]) == k && pos_q[p][k].valid) begin
                            collision_set = 1'b1;
                        end
                    end
                end
            end
        end
        if (flush_in) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q       <= '0;
            collision_q <= 1'b0;
            lat_err_q   <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            collision_q <= collision_q | collision_set;
            lat_err_q   <= lat_err_q | lat_err_set;
        end
    end

    // Scan low index to high, even before odd: the last match is the latest register-file writer.
    always_comb begin
        fwd_hit_out  = '0;
        fwd_data_out = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (pos_q[p][k].valid && pos_q[p][k].addr == fwd_addr_in[q]) begin
                        fwd_hit_out[q]  = 1'b1;
                        fwd_data_out[q] = pos_q[p][k].data;
                    end
                end
            end
        end
    end

    assign wr_en_even_out   = pos_q[0][0].valid;
    assign rt_even_addr_out = pos_q[0][0].addr;
    assign rt_even_data_out = pos_q[0][0].data;
    assign wr_en_odd_out    = pos_q[1][0].valid;
    assign rt_odd_addr_out  = pos_q[1][0].addr;
    assign rt_odd_data_out  = pos_q[1][0].data;
    assign collision_out    = collision_q;
    assign lat_err_out      = lat_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios then random traffic against a retire-schedule model.
module tb_writeback_stage;

    localparam int WIDTH   = 128;
    localparam int LOGSIZE = 7;
    localparam int DEPTH   = 7;
    localparam int NQ      = 6;

    logic                       clk;
    logic                       reset;
    logic                       flush_in;
    logic                       even_valid_in;
    logic [LOGSIZE-1:0]         even_addr_in;
    logic [WIDTH-1:0]           even_data_in;
    logic [2:0]                 even_lat_in;
    logic                       odd_valid_in;
    logic [LOGSIZE-1:0]         odd_addr_in;
    logic [WIDTH-1:0]           odd_data_in;
    logic [2:0]                 odd_lat_in;
    logic [WIDTH-1:0]           rt_even_data_out;
    logic [LOGSIZE-1:0]         rt_even_addr_out;
    logic                       wr_en_even_out;
    logic [WIDTH-1:0]           rt_odd_data_out;
    logic [LOGSIZE-1:0]         rt_odd_addr_out;
    logic                       wr_en_odd_out;
    logic [NQ-1:0][LOGSIZE-1:0] fwd_addr_in;
    logic [NQ-1:0]              fwd_hit_out;
    logic [NQ-1:0][WIDTH-1:0]   fwd_data_out;
    logic                       collision_out;
    logic                       lat_err_out;

    writeback_stage #(.WIDTH(WIDTH), .LOGSIZE(LOGSIZE), .DEPTH(DEPTH), .NQ(NQ)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in),
        .even_valid_in(even_valid_in), .even_addr_in(even_addr_in),
        .even_data_in(even_data_in), .even_lat_in(even_lat_in),
        .odd_valid_in(odd_valid_in), .odd_addr_in(odd_addr_in),
        .odd_data_in(odd_data_in), .odd_lat_in(odd_lat_in),
        .rt_even_data_out(rt_even_data_out), .rt_even_addr_out(rt_even_addr_out),
        .wr_en_even_out(wr_en_even_out),
        .rt_odd_data_out(rt_odd_data_out), .rt_odd_addr_out(rt_odd_addr_out),
        .wr_en_odd_out(wr_en_odd_out),
        .fwd_addr_in(fwd_addr_in), .fwd_hit_out(fwd_hit_out), .fwd_data_out(fwd_data_out),
        .collision_out(collision_out), .lat_err_out(lat_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one scheduled write per (retire cycle, pipe); key = retire_cycle*2 + pipe.
    typedef struct {
        logic [LOGSIZE-1:0] addr;
        logic [WIDTH-1:0]   data;
    } rec_t;

    rec_t sched [int];
    bit   m_col;
    bit   m_lat;
    int   cyc;
    int   n_pass;
    int   n_total;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 2; p++) begin
            logic               en;
            logic [LOGSIZE-1:0] a;
            logic [WIDTH-1:0]   d;
            en = sched.exists(cyc * 2 + p);
            a  = en ? sched[cyc * 2 + p].addr : '0;
            d  = en ? sched[cyc * 2 + p].data : '0;
            if (p == 0) begin
                chk("wr_en_even", WIDTH'(wr_en_even_out), WIDTH'(en));
                chk("rt_even_addr", WIDTH'(rt_even_addr_out), WIDTH'(a));
                chk("rt_even_data", rt_even_data_out, d);
            end else begin
                chk("wr_en_odd", WIDTH'(wr_en_odd_out), WIDTH'(en));
                chk("rt_odd_addr", WIDTH'(rt_odd_addr_out), WIDTH'(a));
                chk("rt_odd_data", rt_odd_data_out, d);
            end
        end
        chk("collision", WIDTH'(collision_out), WIDTH'(m_col));
        chk("lat_err", WIDTH'(lat_err_out), WIDTH'(m_lat));
        for (int q = 0; q < NQ; q++) begin
            int               best_r;
            int               best_p;
            logic [WIDTH-1:0] best_d;
            best_r = -1;
            best_p = -1;
            best_d = '0;
            // Latest retire cycle writes last; odd pipe writes after even in the same cycle.
            foreach (sched[key]) begin
                int r;
                int p;
                r = key / 2;
                p = key % 2;
                if (r >= cyc && r < cyc + DEPTH && sched[key].addr == fwd_addr_in[q] &&
                    (r > best_r || (r == best_r && p > best_p))) begin
                    best_r = r;
                    best_p = p;
                    best_d = sched[key].data;
                end
            end
            chk($sformatf("fwd_hit[%0d]", q), WIDTH'(fwd_hit_out[q]), WIDTH'(best_r >= 0));
            chk($sformatf("fwd_data[%0d]", q), fwd_data_out[q], best_d);
        end
    endtask

    task automatic update_model();
        if (reset) begin
            sched.delete();
            m_col = 1'b0;
            m_lat = 1'b0;
        end else if (flush_in) begin
            sched.delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                logic               v;
                logic [LOGSIZE-1:0] a;
                logic [WIDTH-1:0]   d;
                int                 l;
                v = (p == 0) ? even_valid_in : odd_valid_in;
                a = (p == 0) ? even_addr_in : odd_addr_in;
                d = (p == 0) ? even_data_in : odd_data_in;
                l = (p == 0) ? int'(even_lat_in) : int'(odd_lat_in);
                if (v) begin
                    if (l == 0 || l > DEPTH) begin
                        m_lat = 1'b1;
                    end else begin
                        if (sched.exists((cyc + l) * 2 + p)) m_col = 1'b1;
                        sched[(cyc + l) * 2 + p] = '{addr: a, data: d};
                    end
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_ins();
        reset         = 1'b0;
        flush_in      = 1'b0;
        even_valid_in = 1'b0;
        even_addr_in  = '0;
        even_data_in  = '0;
        even_lat_in   = '0;
        odd_valid_in  = 1'b0;
        odd_addr_in   = '0;
        odd_data_in   = '0;
        odd_lat_in    = '0;
    endtask

    task automatic ins(input int p, input int a, input logic [WIDTH-1:0] d, input int l);
        if (p == 0) begin
            even_valid_in = 1'b1;
            even_addr_in  = LOGSIZE'(a);
            even_data_in  = d;
            even_lat_in   = 3'(l);
        end else begin
            odd_valid_in = 1'b1;
            odd_addr_in  = LOGSIZE'(a);
            odd_data_in  = d;
            odd_lat_in   = 3'(l);
        end
    endtask

    task automatic all_fwd(input int a);
        for (int q = 0; q < NQ; q++) fwd_addr_in[q] = LOGSIZE'(a);
    endtask

    task automatic do_reset();
        clear_ins();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_col   = 1'b0;
        m_lat   = 1'b0;
        clear_ins();
        all_fwd(0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // Idle after reset.
        repeat (10) tick();
        chk("idle_collision", WIDTH'(collision_out), '0);

        // Even insert L=3: retires three cycles later, forwards while in flight.
        all_fwd(5);
        ins(0, 5, {16{8'hA5}}, 3);
        tick();
        clear_ins();
        repeat (2) tick();
        chk("lat3_wr_en", WIDTH'(wr_en_even_out), WIDTH'(1));
        chk("lat3_addr", WIDTH'(rt_even_addr_out), WIDTH'(5));
        chk("lat3_data", rt_even_data_out, {16{8'hA5}});
        repeat (3) tick();

        // Shorter insert lands on the slot of an older one.
        all_fwd(9);
        ins(0, 9, 128'h22, 2);
        tick();
        clear_ins();
        ins(0, 9, 128'h11, 1);
        tick();
        clear_ins();
        chk("coll_data", rt_even_data_out, 128'h11);
        chk("coll_flag", WIDTH'(collision_out), WIDTH'(1));
        repeat (3) tick();

        // Same address in both pipes, same cycle: odd wins forwarding.
        all_fwd(7);
        ins(0, 7, 128'hE, 4);
        ins(1, 7, 128'hD, 4);
        tick();
        clear_ins();
        chk("tie_fwd_data", fwd_data_out[0], 128'hD);
        repeat (5) tick();

        // Illegal latency dropped, max latency retires without collision.
        do_reset();
        all_fwd(3);
        ins(1, 3, 128'h33, 0);
        tick();
        clear_ins();
        chk("lat0_err", WIDTH'(lat_err_out), WIDTH'(1));
        ins(1, 3, 128'h77, 7);
        tick();
        clear_ins();
        repeat (8) tick();
        chk("lat7_no_coll", WIDTH'(collision_out), '0);

        // Flush kills in-flight results and a same-cycle insert.
        all_fwd(4);
        ins(0, 4, 128'h44, 5);
        ins(1, 4, 128'h45, 5);
        tick();
        clear_ins();
        tick();
        flush_in = 1'b1;
        ins(0, 4, 128'h46, 1);
        tick();
        clear_ins();
        repeat (8) tick();

        // Reset mid-flight clears sticky flags.
        ins(0, 2, 128'h1, 3);
        tick();
        clear_ins();
        ins(0, 2, 128'h2, 2);
        tick();
        clear_ins();
        do_reset();
        chk("reset_coll", WIDTH'(collision_out), '0);
        chk("reset_lat", WIDTH'(lat_err_out), '0);
        repeat (4) tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            clear_ins();
            for (int q = 0; q < NQ; q++) fwd_addr_in[q] = LOGSIZE'($urandom_range(0, 15));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int l;
                    l = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, DEPTH));
                    ins(p, int'($urandom_range(0, 15)),
                        {$urandom(), $urandom(), $urandom(), $urandom()}, l);
                end
            end
            flush_in = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            tick();
        end
        clear_ins();
        repeat (DEPTH + 1) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
